line_fill_writer: RTL and testbench

LINE_FILL_WRITER -- requirements
Module: line_fill_writer

---
 rtl/line_fill_writer_pkg.sv | 23 ++
 rtl/line_fill_writer_if.sv | 44 ++++
 rtl/line_fill_writer_store_mask_gen.sv | 30 +++
 rtl/line_fill_writer.sv | 130 +++++++++++++
 tb/tb_line_fill_writer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/line_fill_writer_pkg.sv
// ============================================================================
// line_fill_writer_pkg : shared cache constants and fill FSM state encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package line_fill_writer_pkg;

    localparam int BEAT_W       = 64;
    localparam int DEF_S_OFFSET = 5;
    localparam int DEF_S_INDEX  = 3;
    localparam int DEF_BEATS    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        WRITE = 2'd3
    } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/line_fill_writer_if.sv
// ============================================================================
// line_fill_writer_if : fill/store requests, memory beats and data-array port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface line_fill_writer_if
    import line_fill_writer_pkg::*;
#(
    parameter int S_OFFSET = DEF_S_OFFSET,
    parameter int S_INDEX  = DEF_S_INDEX
);
    logic                        fill_req;
    logic [S_INDEX-1:0]          fill_index;
    logic                        pmem_read;
    logic                        pmem_resp;
    logic [BEAT_W-1:0]           pmem_rdata;
    logic                        st_req;
    logic [S_INDEX-1:0]          st_index;
    logic [S_OFFSET-1:0]         st_offset;
    logic [31:0]                 st_wdata;
    logic [3:0]                  st_mbe;
    logic                        st_ack;
    logic [(2**S_OFFSET)-1:0]    write_en;
    logic [S_INDEX-1:0]          windex;
    logic [8*(2**S_OFFSET)-1:0]  datain;
    logic                        fill_done;
    logic                        busy;

    modport master (
        output fill_req, fill_index, pmem_resp, pmem_rdata,
               st_req, st_index, st_offset, st_wdata, st_mbe,
        input  pmem_read, st_ack, write_en, windex, datain, fill_done, busy
    );

    modport slave (
        input  fill_req, fill_index, pmem_resp, pmem_rdata,
               st_req, st_index, st_offset, st_wdata, st_mbe,
        output pmem_read, st_ack, write_en, windex, datain, fill_done, busy
    );

endinterface

`default_nettype wire

// File: rtl/line_fill_writer_store_mask_gen.sv
// ============================================================================
// store_mask_gen : places a 32-bit store word and its byte enables in a line
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module store_mask_gen
    import line_fill_writer_pkg::*;
#(
    parameter int S_OFFSET = DEF_S_OFFSET
) (
    input  wire logic [S_OFFSET-1:0]         offset_i,
    input  wire logic [3:0]                  mbe_i,
    input  wire logic [31:0]                 wdata_i,
    output logic      [(2**S_OFFSET)-1:0]    mask_o,
    output logic      [8*(2**S_OFFSET)-1:0]  data_o
);
    localparam int LINE_BYTES = 2**S_OFFSET;
    localparam int WORDS      = LINE_BYTES / 4;

    // Stores are word-aligned; the byte-within-word bits carry no meaning.
    logic unused_lsb;
    assign unused_lsb = ^offset_i[1:0];

    assign mask_o = LINE_BYTES'(mbe_i) << {offset_i[S_OFFSET-1:2], 2'b00};
    assign data_o = {WORDS{wdata_i}};

endmodule

`default_nettype wire

// File: rtl/line_fill_writer.sv
// ============================================================================
// line_fill_writer : assembles a memory burst into a cache line and arbitrates
//                    data-array writes between line fills and CPU stores
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module line_fill_writer
    import line_fill_writer_pkg::*;
#(
    parameter int S_OFFSET = DEF_S_OFFSET,
    parameter int S_INDEX  = DEF_S_INDEX,
    parameter int BEATS    = DEF_BEATS
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    line_fill_writer_if.slave bus
);
    localparam int LINE_BYTES = 2**S_OFFSET;
    localparam int LINE_W     = 8 * LINE_BYTES;
    localparam int CNT_W      = $clog2(BEATS) + 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_REQ   = REQ;
    localparam logic [1:0] ST_BURST = BURST;
    localparam logic [1:0] ST_WRITE = WRITE;

    logic [1:0]         state_q, state_d;
    logic [S_INDEX-1:0] index_q, index_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [LINE_W-1:0]  line_q,  line_d;

    logic [LINE_BYTES-1:0] st_mask;
    logic [LINE_W-1:0]     st_data;
    logic                  st_go;

    store_mask_gen #(
        .S_OFFSET (S_OFFSET)
    ) u_store_mask_gen (
        .offset_i (bus.st_offset),
        .mbe_i    (bus.st_mbe),
        .wdata_i  (bus.st_wdata),
        .mask_o   (st_mask),
        .data_o   (st_data)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.fill_req) begin
                    index_d = bus.fill_index;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.pmem_resp) begin
                    line_d[BEAT_W-1:0] = bus.pmem_rdata;
                    cnt_d              = CNT_W'(1);
                    state_d            = (cnt_d == LAST_CNT) ? ST_WRITE : ST_BURST;
                end
            end
            ST_BURST: begin
                if (bus.pmem_resp) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            line_d[b*BEAT_W +: BEAT_W] = bus.pmem_rdata;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == LAST_CNT) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    // Reset gates the store path so a held st_req cannot write while in reset.
    assign st_go = rst_n && (state_q == ST_IDLE) && bus.st_req && !bus.fill_req;

    always_comb begin
        bus.write_en  = '0;
        bus.windex    = '0;
        bus.datain    = '0;
        bus.fill_done = 1'b0;
        if (state_q == ST_WRITE) begin
            bus.write_en  = '1;
            bus.windex    = index_q;
            bus.datain    = line_q;
            bus.fill_done = 1'b1;
        end else if (st_go) begin
            bus.write_en = st_mask;
            bus.windex   = bus.st_index;
            bus.datain   = st_data;
        end
    end

    assign bus.st_ack    = st_go;
    assign bus.pmem_read = (state_q == ST_REQ);
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_line_fill_writer.sv
// ============================================================================
// tb_line_fill_writer : randomized self-checking bench with a line-level model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_line_fill_writer;
    import line_fill_writer_pkg::*;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int BEATS    = 4;
    localparam int LB       = 32;
    localparam int LW       = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_fill_writer_if #(.S_OFFSET(S_OFFSET), .S_INDEX(S_INDEX)) bus ();

    line_fill_writer #(
        .S_OFFSET (S_OFFSET),
        .S_INDEX  (S_INDEX),
        .BEATS    (BEATS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte b is enabled when it lies in the addressed word and its lane is enabled.
    function automatic logic [LB-1:0] ref_mask(input int off, input logic [3:0] mbe);
        logic [LB-1:0] m = '0;
        for (int b = 0; b < LB; b++)
            if (b / 4 == off / 4) m[b] = mbe[b % 4];
        return m;
    endfunction

    function automatic logic [LW-1:0] ref_data(input logic [31:0] w);
        logic [LW-1:0] d = '0;
        for (int k = 0; k < LW / 32; k++) d[k*32 +: 32] = w;
        return d;
    endfunction

    task automatic clear_inputs();
        bus.fill_req   = 1'b0;
        bus.fill_index = '0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        bus.st_req     = 1'b0;
        bus.st_index   = '0;
        bus.st_offset  = '0;
        bus.st_wdata   = '0;
        bus.st_mbe     = '0;
    endtask

    task automatic set_store(input logic [2:0] idx, input logic [4:0] off,
                             input logic [3:0] mbe, input logic [31:0] wd);
        bus.st_req    = 1'b1;
        bus.st_index  = idx;
        bus.st_offset = off;
        bus.st_mbe    = mbe;
        bus.st_wdata  = wd;
    endtask

    task automatic check_store_write(input string tag, input logic [2:0] idx, input logic [4:0] off,
                                     input logic [3:0] mbe, input logic [31:0] wd);
        check({tag, "_ack"},    bus.st_ack,   1'b1);
        check({tag, "_windex"}, bus.windex,   idx);
        check({tag, "_wen"},    bus.write_en, ref_mask(int'(off), mbe));
        check({tag, "_datain"}, bus.datain,   ref_data(wd));
        check({tag, "_busy"},   bus.busy,     1'b0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] idx, input logic [4:0] off,
                            input logic [3:0] mbe, input logic [31:0] wd);
        @(negedge clk);
        set_store(idx, off, mbe, wd);
        #1;
        check_store_write(tag, idx, off, mbe, wd);
        @(posedge clk);
        #1 bus.st_req = 1'b0;
    endtask

    // One complete fill transaction; rst_after>0 asserts reset after that many beats.
    task automatic do_fill(input string tag, input logic [2:0] idx, input bit directed,
                           input int gapmax, input bit hold_req, input bit with_store,
                           input int rst_after);
        logic [63:0]   beats[BEATS];
        logic [LW-1:0] line = '0;
        logic [2:0]    s_idx = 3'($urandom);
        logic [4:0]    s_off = 5'($urandom);
        logic [3:0]    s_mbe = 4'($urandom);
        logic [31:0]   s_wd  = $urandom;
        for (int i = 0; i < BEATS; i++) begin
            beats[i] = directed ? 64'(i + 1) : {$urandom, $urandom};
            line     = line | (LW'(beats[i]) << (64 * i));
        end

        @(negedge clk);
        bus.fill_req   = 1'b1;
        bus.fill_index = idx;
        if (with_store) set_store(s_idx, s_off, s_mbe, s_wd);
        #1;
        check({tag, "_accept_ack"}, bus.st_ack,   1'b0);
        check({tag, "_accept_wen"}, bus.write_en, '0);

        for (int i = 0; i < BEATS; i++) begin
            int gaps = int'($urandom_range(gapmax, 0));
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                bus.fill_req   = hold_req;
                bus.fill_index = ~idx;
                bus.pmem_resp  = 1'b0;
                bus.pmem_rdata = {$urandom, $urandom};
                #1;
                check({tag, "_gap_read"}, bus.pmem_read, (i == 0));
                check({tag, "_gap_busy"}, bus.busy,      1'b1);
                check({tag, "_gap_wen"},  bus.write_en,  '0);
                check({tag, "_gap_ack"},  bus.st_ack,    1'b0);
            end
            @(negedge clk);
            bus.fill_req   = hold_req;
            bus.fill_index = ~idx;
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = beats[i];
            #1;
            check({tag, "_beat_read"}, bus.pmem_read, (i == 0));
            check({tag, "_beat_wen"},  bus.write_en,  '0);
            check({tag, "_beat_done"}, bus.fill_done, 1'b0);
            if (i + 1 == rst_after) begin
                @(negedge clk);
                clear_inputs();
                rst_n = 1'b0;
                #1;
                check({tag, "_rst_busy"}, bus.busy,      1'b0);
                check({tag, "_rst_read"}, bus.pmem_read, 1'b0);
                check({tag, "_rst_wen"},  bus.write_en,  '0);
                check({tag, "_rst_done"}, bus.fill_done, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check({tag, "_post_rst_wen"},  bus.write_en, '0);
                check({tag, "_post_rst_busy"}, bus.busy,     1'b0);
                return;
            end
        end

        @(negedge clk);
        bus.fill_req  = 1'b0;
        bus.pmem_resp = 1'b0;
        #1;
        check({tag, "_wr_wen"},    bus.write_en,  {LB{1'b1}});
        check({tag, "_wr_windex"}, bus.windex,    idx);
        check({tag, "_wr_datain"}, bus.datain,    line);
        check({tag, "_wr_done"},   bus.fill_done, 1'b1);
        check({tag, "_wr_ack"},    bus.st_ack,    1'b0);
        check({tag, "_wr_read"},   bus.pmem_read, 1'b0);

        @(negedge clk);
        #1;
        check({tag, "_after_done"}, bus.fill_done, 1'b0);
        check({tag, "_after_busy"}, bus.busy,      1'b0);
        if (with_store) begin
            check_store_write({tag, "_held_st"}, s_idx, s_off, s_mbe, s_wd);
            @(posedge clk);
            #1 bus.st_req = 1'b0;
        end else begin
            check({tag, "_after_wen"}, bus.write_en, '0);
        end
    endtask

    initial begin
        clear_inputs();
        bus.st_req    = 1'b1;
        bus.st_mbe    = 4'hF;
        bus.fill_req  = 1'b0;
        bus.pmem_resp = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", bus.busy,      1'b0);
        check("reset_read", bus.pmem_read, 1'b0);
        check("reset_done", bus.fill_done, 1'b0);
        check("reset_wen",  bus.write_en,  '0);
        check("reset_ack",  bus.st_ack,    1'b0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        do_store("st_dir", 3'd2, 5'd8, 4'b0101, 32'hAABBCCDD);
        do_store("st_mbe0", 3'd6, 5'd20, 4'b0000, 32'h12345678);
        do_store("st_lsb", 3'd1, 5'd31, 4'b1001, 32'hCAFEF00D);

        do_fill("fill_dir",  3'd5, 1'b1, 0, 1'b0, 1'b0, 0);
        do_fill("fill_gap",  3'd3, 1'b0, 3, 1'b1, 1'b0, 0);
        do_fill("fill_st",   3'd7, 1'b0, 2, 1'b0, 1'b1, 0);
        do_fill("fill_rst",  3'd4, 1'b0, 1, 1'b0, 1'b0, 2);
        do_fill("fill_new",  3'd6, 1'b0, 1, 1'b0, 1'b0, 0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(2, 0))
                0: do_store("rnd_st", 3'($urandom), 5'($urandom), 4'($urandom), $urandom);
                1: do_fill("rnd_fill", 3'($urandom), 1'b0, 3, 1'($urandom), 1'($urandom), 0);
                default: begin
                    @(negedge clk);
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = {$urandom, $urandom};
                    #1;
                    check("idle_resp_wen", bus.write_en, '0);
                    @(negedge clk);
                    bus.pmem_resp = 1'b0;
                    #1;
                    check("idle_resp_busy", bus.busy,      1'b0);
                    check("idle_resp_read", bus.pmem_read, 1'b0);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
